// File: rtl/demux_pkg.sv
// Shared types and sizes for the 1-to-16 registered demultiplexer.
// Keeps the select width and port count in one place for the decoder and the top.
package demux_pkg;

  localparam int SEL_W   = 4;
  localparam int NUM_OUT = 16;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/decode_4to16.sv
// Combinational 4-to-16 one-hot decoder with enable.
// The output is all-zero when en is low.
import demux_pkg::*;

module decode_4to16 (
  input  logic               en,
  input  sel_t               select,
  output logic [NUM_OUT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[select] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_thicc_16.sv
// Registered 1-to-16 data demultiplexer: in goes to out_<select>, all other ports drive zero.
// One clock of latency; out_sel flags the port carrying data so a routed zero can be told apart.
import demux_pkg::*;

module demux_thicc_16 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [WIDTH-1:0]   in,
  input  sel_t               select,
  output logic [WIDTH-1:0]   out_0,
  output logic [WIDTH-1:0]   out_1,
  output logic [WIDTH-1:0]   out_2,
  output logic [WIDTH-1:0]   out_3,
  output logic [WIDTH-1:0]   out_4,
  output logic [WIDTH-1:0]   out_5,
  output logic [WIDTH-1:0]   out_6,
  output logic [WIDTH-1:0]   out_7,
  output logic [WIDTH-1:0]   out_8,
  output logic [WIDTH-1:0]   out_9,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic [WIDTH-1:0]   out_c,
  output logic [WIDTH-1:0]   out_d,
  output logic [WIDTH-1:0]   out_e,
  output logic [WIDTH-1:0]   out_f,
  output logic [NUM_OUT-1:0] out_sel
);

  logic [NUM_OUT-1:0]            route;
  logic [NUM_OUT-1:0][WIDTH-1:0] port_d;
  logic [NUM_OUT-1:0][WIDTH-1:0] port_q;
  logic [NUM_OUT-1:0]            sel_q;

  decode_4to16 u_decode (
    .en     (en),
    .select (select),
    .onehot (route)
  );

  // Each port's next value is in gated by its decode bit, so a select change
  // clears the old port on the same edge the new one loads.
  always_comb begin
    port_d = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      port_d[k] = route[k] ? in : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_q <= '0;
      sel_q  <= '0;
    end else begin
      port_q <= port_d;
      sel_q  <= route;
    end
  end

  assign out_0   = port_q[0];
  assign out_1   = port_q[1];
  assign out_2   = port_q[2];
  assign out_3   = port_q[3];
  assign out_4   = port_q[4];
  assign out_5   = port_q[5];
  assign out_6   = port_q[6];
  assign out_7   = port_q[7];
  assign out_8   = port_q[8];
  assign out_9   = port_q[9];
  assign out_a   = port_q[10];
  assign out_b   = port_q[11];
  assign out_c   = port_q[12];
  assign out_d   = port_q[13];
  assign out_e   = port_q[14];
  assign out_f   = port_q[15];
  assign out_sel = sel_q;

endmodule

// File: tb/tb_demux_thicc_16.sv
// Directed self-checking bench for demux_thicc_16 with WIDTH=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point after the next edge.
module tb_demux_thicc_16;

  logic        clk;
  logic        reset;
  logic        en;
  logic [7:0]  in;
  logic [3:0]  select;
  logic [7:0]  out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7;
  logic [7:0]  out_8, out_9, out_a, out_b, out_c, out_d, out_e, out_f;
  logic [15:0] out_sel;

  int total = 0;
  int bad   = 0;

  wire [15:0][7:0] outs = {out_f, out_e, out_d, out_c, out_b, out_a, out_9, out_8,
                           out_7, out_6, out_5, out_4, out_3, out_2, out_1, out_0};

  demux_thicc_16 #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .in      (in),
    .select  (select),
    .out_0   (out_0),
    .out_1   (out_1),
    .out_2   (out_2),
    .out_3   (out_3),
    .out_4   (out_4),
    .out_5   (out_5),
    .out_6   (out_6),
    .out_7   (out_7),
    .out_8   (out_8),
    .out_9   (out_9),
    .out_a   (out_a),
    .out_b   (out_b),
    .out_c   (out_c),
    .out_d   (out_d),
    .out_e   (out_e),
    .out_f   (out_f),
    .out_sel (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Only port k may carry val; every other port must read zero.
  task automatic chk_ports(input string tag, input int k, input logic [7:0] val);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("%s_out%0h", tag, j), {24'h0, outs[j]}, (j == k) ? {24'h0, val} : 32'h0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nz;
    reset = 1'b1; en = 1'b1; in = 8'hFF; select = 4'd3;
    step();
    chk_ports("reset", -1, 8'h00);
    chk("reset_sel", {16'h0, out_sel}, 32'h0000);

    reset = 1'b0;
    step();
    chk("rel_out3", {24'h0, out_3}, 32'hFF);
    chk("rel_out2", {24'h0, out_2}, 32'h00);
    chk("rel_sel", {16'h0, out_sel}, 32'h0008);

    select = 4'd0; in = 8'h5A;
    step();
    chk("basic_out0", {24'h0, out_0}, 32'h5A);
    chk("basic_out1", {24'h0, out_1}, 32'h00);
    chk("basic_outc", {24'h0, out_c}, 32'h00);
    chk("basic_out3", {24'h0, out_3}, 32'h00);
    chk("basic_sel", {16'h0, out_sel}, 32'h0001);

    in = 8'h0F;
    step();
    chk("upd_out0", {24'h0, out_0}, 32'h0F);
    chk("upd_out1", {24'h0, out_1}, 32'h00);
    chk("upd_outc", {24'h0, out_c}, 32'h00);

    select = 4'd4;
    step();
    chk("sw_out0", {24'h0, out_0}, 32'h00);
    chk("sw_out4", {24'h0, out_4}, 32'h0F);
    chk("sw_outb", {24'h0, out_b}, 32'h00);
    chk("sw_sel", {16'h0, out_sel}, 32'h0010);
    nz = 0;
    for (int j = 0; j < 16; j++) if (outs[j] != 8'h00) nz++;
    chk("sw_nonzero_count", nz, 1);

    en = 1'b0; select = 4'hF; in = 8'hA5;
    step();
    chk_ports("dis", -1, 8'h00);
    chk("dis_sel", {16'h0, out_sel}, 32'h0000);

    en = 1'b1;
    step();
    chk("en_outf", {24'h0, out_f}, 32'hA5);
    chk("en_sel", {16'h0, out_sel}, 32'h8000);

    for (int k = 0; k < 16; k++) begin
      select = 4'(k); in = 8'(8'h10 + k);
      step();
      chk_ports($sformatf("sweep%0d", k), k, 8'(8'h10 + k));
      chk($sformatf("sweep%0d_sel", k), {16'h0, out_sel}, 32'h1 << k);
    end

    select = 4'd7; in = 8'h00;
    step();
    chk_ports("zero", 7, 8'h00);
    chk("zero_sel", {16'h0, out_sel}, 32'h0080);

    select = 4'd9; in = 8'h33;
    step();
    chk("pre_out9", {24'h0, out_9}, 32'h33);
    chk("pre_sel", {16'h0, out_sel}, 32'h0200);

    // Inputs change mid-cycle: registered outputs must hold until the next edge.
    select = 4'd2; in = 8'h77;
    #2;
    chk("nocomb_out9", {24'h0, out_9}, 32'h33);
    chk("nocomb_out2", {24'h0, out_2}, 32'h00);
    select = 4'd9; in = 8'h33;

    reset = 1'b1;
    step();
    chk_ports("midrst", -1, 8'h00);
    chk("midrst_sel", {16'h0, out_sel}, 32'h0000);

    reset = 1'b0;
    step();
    chk("resume_out9", {24'h0, out_9}, 32'h33);
    chk("resume_sel", {16'h0, out_sel}, 32'h0200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
